// File: rtl/sd_mem_arbiter.sv
// Two-port arbiter in front of a fixed-latency byte memory: SD reader (A) has priority,
// loader/debug port (B) is protected from starvation; completions return in issue order.
module sd_mem_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int B_MAX_WAIT = 16
) (
   input  logic        sdclk,
   input  logic        rst_n,
   input  logic        a_req,
   input  logic [63:0] a_addr,
   output logic        a_gnt,
   output logic        a_valid,
   output logic [7:0]  a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [63:0] b_addr,
   input  logic [7:0]  b_wdata,
   output logic        b_gnt,
   output logic        b_valid,
   output logic [7:0]  b_rdata,
   output logic        b_err,
   input  logic        wp,
   output logic        mem_en,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   we;
      logic   err;
   } tag_t;

   localparam logic [7:0] B_MAX_W8 = 8'(B_MAX_WAIT);

   logic [7:0] wait_q, wait_d;
   tag_t       pipe_q [MEM_LAT];
   tag_t       pipe_d [MEM_LAT];
   tag_t       new_tag;
   tag_t       exit_tag;
   logic       starve;

   logic       a_valid_q, a_valid_d;
   logic [7:0] a_rdata_q, a_rdata_d;
   logic       b_valid_q, b_valid_d;
   logic [7:0] b_rdata_q, b_rdata_d;
   logic       b_err_q, b_err_d;

   // Grant and memory-side mux; grants are gated by rst_n so nothing issues during reset.
   always_comb begin
      starve    = b_req && (wait_q >= B_MAX_W8);
      a_gnt     = rst_n & a_req & ~starve;
      b_gnt     = rst_n & b_req & (~a_req | starve);
      mem_en    = a_gnt | b_gnt;
      mem_we    = b_gnt & b_we & ~wp;
      mem_addr  = b_gnt ? b_addr : a_addr;
      mem_wdata = b_gnt ? b_wdata : '0;
   end

   always_comb begin
      wait_d = wait_q;
      if (!b_req || b_gnt) begin
         wait_d = '0;
      end else if (wait_q != 8'hFF) begin
         wait_d = wait_q + 8'd1;
      end
   end

   // Tag pipeline: depth MEM_LAT so the tag leaves in the cycle mem_rdata is valid.
   always_comb begin
      new_tag.valid = mem_en;
      new_tag.owner = b_gnt ? OWN_B : OWN_A;
      new_tag.we    = b_gnt & b_we;
      new_tag.err   = b_gnt & b_we & wp;
      pipe_d[0]     = new_tag;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      exit_tag = pipe_q[MEM_LAT-1];
   end

   always_comb begin
      a_valid_d = exit_tag.valid && (exit_tag.owner == OWN_A);
      b_valid_d = exit_tag.valid && (exit_tag.owner == OWN_B);
      b_err_d   = b_valid_d && exit_tag.err;
      a_rdata_d = a_valid_d ? mem_rdata : a_rdata_q;
      b_rdata_d = (b_valid_d && !exit_tag.we) ? mem_rdata : b_rdata_q;
   end

   always_ff @(posedge sdclk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q    <= '0;
         a_valid_q <= 1'b0;
         a_rdata_q <= '0;
         b_valid_q <= 1'b0;
         b_rdata_q <= '0;
         b_err_q   <= 1'b0;
         for (int unsigned i = 0; i < MEM_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         wait_q    <= wait_d;
         a_valid_q <= a_valid_d;
         a_rdata_q <= a_rdata_d;
         b_valid_q <= b_valid_d;
         b_rdata_q <= b_rdata_d;
         b_err_q   <= b_err_d;
         for (int unsigned i = 0; i < MEM_LAT; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign a_valid = a_valid_q;
   assign a_rdata = a_rdata_q;
   assign b_valid = b_valid_q;
   assign b_rdata = b_rdata_q;
   assign b_err   = b_err_q;

endmodule
